// File: rtl/controle_acumulador.sv
`default_nettype none
// ============================================================================
//  Module   : controle_acumulador
//  Purpose  : Sequencing controller for an external one-cycle registered
//             adder. Accepts a burst of operands over a valid/ready stream,
//             accumulates them through the adder and reports the final total
//             with a done pulse, a busy flag and a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module controle_acumulador #(
    parameter int WIDTH = 44,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_ADD     = 3'd2,
        S_CAPT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] remaining_q;
    logic             overflow_q;

    // An unsigned sum smaller than one of its addends means it wrapped.
    logic             wrap_d;
    assign wrap_d = (add_s < acc_q);

    // Operands go to the adder straight from registers so the adder never
    // sees a combinational path from in_data.
    assign add_a    = acc_q;
    assign add_b    = op_b_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign count    = count_q;
    assign in_ready = (state_q == S_WAIT_IN);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

    // Burst sequencer: WAIT_IN -> ADD -> CAPT per operand, DONE once at the end.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q       <= '0;
                        count_q     <= '0;
                        overflow_q  <= 1'b0;
                        result_q    <= '0;
                        remaining_q <= len;
                        state_q     <= (len == '0) ? S_DONE : S_WAIT_IN;
                    end
                end
                S_WAIT_IN: begin
                    // in_ready is implied by being in this state.
                    if (in_valid) begin
                        op_b_q  <= in_data;
                        count_q <= count_q + 1'b1;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    // Adder samples add_a/add_b at the end of this cycle.
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    acc_q       <= add_s;
                    remaining_q <= remaining_q - 1'b1;
                    if (wrap_d) begin
                        overflow_q <= 1'b1;
                    end
                    if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        result_q <= add_s;
                        state_q  <= S_DONE;
                    end else begin
                        state_q  <= S_WAIT_IN;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controle_acumulador.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controle_acumulador
//  Purpose  : Self-checking bench for controle_acumulador with a behavioural
//             one-cycle registered adder and a queued operand source.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controle_acumulador;

    localparam int WIDTH = 44;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_s = '0;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] count;

    controle_acumulador #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_s    (add_s),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .overflow (overflow),
        .count    (count)
    );

    always #5 clock = ~clock;

    // Behavioural model of the external somador (one-cycle registered adder).
    always @(posedge clock) add_s <= add_a + add_b;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ov;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ov;
        logic [CNT_W-1:0] cnt;
        int               cyc;
    } got_t;

    exp_t             exp_q[$];
    got_t             got_q[$];
    logic [WIDTH-1:0] src_q[$];
    int               stl_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int done_cnt = 0;
    int consumed = 0;
    int rdy_seen = 0;
    int stall_rdy = 0;

    // Present the head of the source queue unless it still has stall cycles.
    task automatic drive();
        if (src_q.size() > 0 && stl_q[0] == 0) begin
            in_valid = 1'b1;
            in_data  = src_q[0];
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock: drive, sample handshake before the edge, record after it.
    task automatic step();
        logic hs;
        logic st;
        drive();
        hs = in_valid && in_ready;
        st = in_ready && !in_valid;
        if (in_ready) rdy_seen++;
        if (st) stall_rdy++;
        @(posedge clock);
        #1;
        cyc++;
        if (hs) begin
            void'(src_q.pop_front());
            void'(stl_q.pop_front());
            consumed++;
        end else if (st && stl_q.size() > 0 && stl_q[0] > 0) begin
            stl_q[0] = stl_q[0] - 1;
        end
        if (done) begin
            got_t g;
            g.res = result;
            g.ov  = overflow;
            g.cnt = count;
            g.cyc = cyc;
            got_q.push_back(g);
            done_cnt++;
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] v, input int stall);
        src_q.push_back(v);
        stl_q.push_back(stall);
    endtask

    task automatic start_burst(input logic [CNT_W-1:0] l, input logic [WIDTH-1:0] r,
                               input logic ov);
        exp_t e;
        e.res = r;
        e.ov  = ov;
        exp_q.push_back(e);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if ({result, count, overflow, add_a, add_b} !== '0) begin
            n_fail++; $display("FAIL reset_regs: result=%0d count=%0d ov=%b a=%0d b=%0d want all 0",
                               result, count, overflow, add_a, add_b);
        end
        @(negedge clock);
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_basic();
        bit   ok;
        got_t g;
        exp_t e;
        load(44'd4, 0); load(44'd8, 0); load(44'd11, 0);
        start_burst(8'd3, 44'd23, 1'b0);
        n_tests++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_cycle1: in_ready=%b busy=%b want 1 1", in_ready, busy);
        end
        run_until_done(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
        if (ok) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g.res !== e.res) begin n_fail++; $display("FAIL basic_result: got %0d want %0d", g.res, e.res); end
            n_tests++; if (g.cyc - t0 + 1 !== 10) begin n_fail++; $display("FAIL basic_latency: got %0d want 10", g.cyc - t0 + 1); end
            n_tests++; if (g.cnt !== 8'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", g.cnt); end
            n_tests++; if (g.ov !== e.ov) begin n_fail++; $display("FAIL basic_overflow: got %b want %b", g.ov, e.ov); end
        end
        step();
        step();
        n_tests++; if (result !== 44'd23 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_hold: result=%0d busy=%b want 23 0", result, busy);
        end
    endtask

    task automatic test_wrap();
        bit   ok;
        got_t g;
        exp_t e;
        load(44'hFFF_FFFF_FFFF, 0); load(44'd1, 0);
        start_burst(8'd2, 44'd0, 1'b1);
        n_tests++; if (result !== 44'd0) begin n_fail++; $display("FAIL wrap_result_cleared: got %0d want 0", result); end
        run_until_done(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: no done within budget"); end
        if (ok) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g.res !== e.res) begin n_fail++; $display("FAIL wrap_result: got %0d want %0d", g.res, e.res); end
            n_tests++; if (g.ov !== e.ov) begin n_fail++; $display("FAIL wrap_overflow: got %b want %b", g.ov, e.ov); end
        end
        step();
        load(44'd5, 0);
        start_burst(8'd1, 44'd5, 1'b0);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ov_cleared: got %b want 0", overflow); end
        run_until_done(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap2_timeout: no done within budget"); end
        if (ok) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g.res !== e.res || g.ov !== e.ov) begin
                n_fail++; $display("FAIL wrap2_result: got %0d ov=%b want %0d ov=%b", g.res, g.ov, e.res, e.ov);
            end
            n_tests++; if (g.cyc - t0 + 1 !== 4) begin n_fail++; $display("FAIL wrap2_latency: got %0d want 4", g.cyc - t0 + 1); end
        end
        step();
    endtask

    task automatic test_zero_len();
        bit   ok;
        got_t g;
        exp_t e;
        rdy_seen = 0;
        start_burst(8'd0, 44'd0, 1'b0);
        run_until_done(1, ok);
        if (!ok && got_q.size() > 0) ok = 1'b1;
        n_tests++; if (got_q.size() == 0) begin n_fail++; $display("FAIL zero_timeout: no done"); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g.cyc - t0 + 1 !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1", g.cyc - t0 + 1); end
            n_tests++; if (g.res !== e.res) begin n_fail++; $display("FAIL zero_result: got %0d want %0d", g.res, e.res); end
        end
        step();
        step();
        n_tests++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL zero_in_ready: asserted %0d cycles want 0", rdy_seen); end
    endtask

    task automatic test_backpressure();
        bit   ok;
        got_t g;
        exp_t e;
        int   c0;
        c0 = consumed;
        stall_rdy = 0;
        load(44'd38, 0); load(44'd62, 4);
        start_burst(8'd2, 44'd100, 1'b0);
        run_until_done(60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
        if (ok) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g.res !== e.res) begin n_fail++; $display("FAIL bp_result: got %0d want %0d", g.res, e.res); end
            n_tests++; if (g.cyc - t0 + 1 !== 11) begin n_fail++; $display("FAIL bp_latency: got %0d want 11", g.cyc - t0 + 1); end
            n_tests++; if (g.cnt !== 8'd2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", g.cnt); end
        end
        n_tests++; if (stall_rdy !== 4) begin n_fail++; $display("FAIL bp_ready_stall: got %0d cycles want 4", stall_rdy); end
        n_tests++; if (consumed - c0 !== 2) begin n_fail++; $display("FAIL bp_consumed: got %0d want 2", consumed - c0); end
        step();
    endtask

    task automatic test_start_during_burst();
        bit   ok;
        got_t g;
        exp_t e;
        int   d0;
        d0 = done_cnt;
        load(44'd40, 0); load(44'd11, 0);
        start_burst(8'd2, 44'd51, 1'b0);
        step();
        start = 1'b1;
        len   = 8'd7;
        step();
        start = 1'b0;
        run_until_done(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL sdb_timeout: no done within budget"); end
        if (ok) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g.res !== e.res) begin n_fail++; $display("FAIL sdb_result: got %0d want %0d", g.res, e.res); end
            n_tests++; if (g.cyc - t0 + 1 !== 7) begin n_fail++; $display("FAIL sdb_latency: got %0d want 7", g.cyc - t0 + 1); end
            n_tests++; if (g.cnt !== 8'd2) begin n_fail++; $display("FAIL sdb_count: got %0d want 2", g.cnt); end
        end
        for (int i = 0; i < 6; i++) step();
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL sdb_done_pulses: got %0d want 1", done_cnt - d0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sdb_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        got_t g;
        exp_t e;
        int   d0;
        d0 = done_cnt;
        load(44'd1, 0); load(44'd2, 0); load(44'd3, 0);
        start = 1'b1;
        len   = 8'd3;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl: busy=%b in_ready=%b done=%b want 0 0 0", busy, in_ready, done);
        end
        n_tests++; if ({result, count, overflow, add_a, add_b} !== '0) begin
            n_fail++; $display("FAIL rstmid_regs: result=%0d count=%0d ov=%b a=%0d b=%0d want all 0",
                               result, count, overflow, add_a, add_b);
        end
        src_q.delete();
        stl_q.delete();
        step();
        rst_n = 1'b1;
        step();
        n_tests++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); end
        load(44'd9, 0);
        start_burst(8'd1, 44'd9, 1'b0);
        run_until_done(40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: no done within budget"); end
        if (ok) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_tests++; if (g.res !== e.res) begin n_fail++; $display("FAIL rstmid_result: got %0d want %0d", g.res, e.res); end
        end
        step();
        n_tests++; if (got_q.size() !== 0 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_leftover: got_q=%0d exp_q=%0d want 0 0", got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_start_during_burst();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
